t_ff_seq_ctrl: RTL and testbench
================================

// Module: t_ff_seq_ctrl
// PURPOSE
//  Sequencer for a bank of WIDTH toggle flip-flops (one t_ff cell per bit, same clk).
//  Drives each cell's T input and reads back each cell's q, so that the bank acts as a
//  commandable register: count up N steps, count down N steps, load a value, or clear.
//  Sits between a command master (start/done handshake) and the T-FF bank.
// PARAMETERS
//  WIDTH  4  number of T-FF cells driven (t_vec/q_vec width)
//  CW     8  width of the step count (max 2^CW-1 steps per command)
// PORTS
//  clk       in   1      rising-edge clock, shared with the T-FF bank
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      command strobe; sampled only in IDLE
//  cmd       in   2      0=COUNT_UP 1=COUNT_DOWN 2=LOAD 3=CLEAR; latched on accepted start
//  steps     in   CW     toggle-step count for COUNT_UP/DOWN; latched on accepted start
//  load_val  in   WIDTH  target value for LOAD; latched on accepted start
//  abort     in   1      cancel the current command
//  q_vec     in   WIDTH  q outputs of the T-FF bank (bit i = cell i)
//  t_vec     out  WIDTH  T inputs of the T-FF bank (combinational from state, q_vec)
//  busy      out  1      high in RUN and APPLY
//  done      out  1      one-cycle pulse on command completion
//  wrap      out  1      high in a RUN cycle whose toggle wraps the bank (F->0 up, 0->F down)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, step counter=0, latched cmd/load_val=0;
//   t_vec=0, busy=0, done=0, wrap=0 immediately, without waiting for a clock edge.
//  States: IDLE, RUN, APPLY, DONE.
//  IDLE: t_vec=0. start=1 latches cmd/steps/load_val.
//   COUNT_UP/DOWN with steps>0 -> RUN; with steps=0 -> DONE (no toggles).
//   LOAD/CLEAR -> APPLY.
//  RUN: for exactly `steps` consecutive cycles t_vec = toggle mask from the live q_vec:
//   up:   t[0]=1, t[i]=&q_vec[i-1:0];   down: t[0]=1, t[i]=&(~q_vec[i-1:0]).
//   The bank updates on the same edge, so each RUN cycle advances the value by exactly +/-1.
//   Step counter decrements each RUN cycle; on the last step -> DONE.
//   wrap = up ? &q_vec : ~|q_vec (RUN only; 0 elsewhere).
//  APPLY: one cycle, t_vec = q_vec ^ target (target = load_val for LOAD, 0 for CLEAR) -> DONE.
//   A target equal to q_vec gives t_vec=0; the command still completes.
//  DONE: t_vec=0, busy=0, done=1 for this single cycle -> IDLE. start here is ignored.
//  start while busy or in DONE: ignored, not queued; latched operands unchanged.
//  abort=1 in RUN/APPLY: t_vec forced to 0 in that same cycle; -> IDLE next edge;
//   no done pulse; bank keeps its current value. abort in IDLE/DONE: no effect.
//  abort and start together in IDLE: abort wins; the command is not accepted.
//  Reset asserted mid-command: t_vec drops to 0 at once; the command is lost; no done.
//  Counter arithmetic is modulo 2^WIDTH; wrap is indication only and never stalls.
//  Latency: COUNT = steps+1 cycles start->done (1 for steps=0); LOAD/CLEAR = 2 cycles.
// TESTING (WIDTH=4, bench models the bank as WIDTH behavioural T-FFs with same reset)
//  1. reset=0 with q_vec=0 -> t_vec=0, busy=0, done=0, wrap=0; release -> outputs unchanged.
//  2. q=0, start COUNT_UP steps=5 -> t_vec 1,3,1,7,1 on consecutive cycles; q=5; done 1 cycle
//     later; busy high exactly 5 cycles.
//  3. q=0, start COUNT_DOWN steps=2 -> t_vec F (wrap=1) then 1 (wrap=0); final q=E; done pulse.
//  4. q=5, start LOAD load_val=A -> one APPLY cycle with t_vec=F; q=A; done next cycle;
//     then CLEAR -> t_vec=A, q=0.
//  5. COUNT_UP steps=8 from 0, abort in the 3rd RUN cycle -> t_vec=0 that cycle; q holds 2;
//     no done; busy=0 next cycle; new start accepted.
//  6. start pulsed again while busy (cmd=CLEAR) -> ignored, count completes; reset=0 mid-RUN
//     -> t_vec=0 immediately, state IDLE, no done.

Source files
------------

// File: rtl/t_ff_seq_ctrl.sv
// Command sequencer for a bank of toggle flip-flops: counts up/down N steps, loads or clears
// the bank by driving per-cell T inputs computed from the live q outputs.
module t_ff_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       cmd,
  input  logic [CW-1:0]    steps,
  input  logic [WIDTH-1:0] load_val,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_vec,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [1:0] CMD_UP    = 2'd0;
  localparam logic [1:0] CMD_DOWN  = 2'd1;
  localparam logic [1:0] CMD_LOAD  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;

  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic [WIDTH-1:0] target;

  // Ripple-carry / ripple-borrow toggle masks from the live bank value.
  always_comb begin
    up_mask    = '0;
    dn_mask    = '0;
    up_mask[0] = 1'b1;
    dn_mask[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_mask[i] = up_mask[i-1] & q_vec[i-1];
      dn_mask[i] = dn_mask[i-1] & ~q_vec[i-1];
    end
  end

  assign target = (cmd_q == CMD_LOAD) ? load_val_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= CMD_UP;
      load_val_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      load_val_q <= load_val_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    load_val_d = load_val_q;
    t_vec      = '0;
    wrap       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          cmd_d      = cmd;
          cnt_d      = steps;
          load_val_d = load_val;
          if (cmd == CMD_UP || cmd == CMD_DOWN) begin
            state_d = (steps == '0) ? S_DONE : S_RUN;
          end else begin
            state_d = S_APPLY;
          end
        end
      end

      S_RUN: begin
        busy = 1'b1;
        wrap = (cmd_q == CMD_UP) ? (&q_vec) : ~(|q_vec);
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          t_vec = (cmd_q == CMD_UP) ? up_mask : dn_mask;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_APPLY: begin
        busy = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          t_vec   = q_vec ^ target;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // CMD_DOWN and CMD_CLEAR are decoded implicitly above; keep them referenced for readability.
  logic unused_codes;
  assign unused_codes = (CMD_DOWN != CMD_CLEAR);

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Self-checking bench: behavioural T-FF bank, directed table, random commands against an
// arithmetic value model, and hand-written abort/reset sequences.
module tb_t_ff_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       cmd;
  logic [CW-1:0]    steps;
  logic [WIDTH-1:0] load_val;
  logic             abort;
  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             done;
  logic             wrap;

  int nvec;
  int nerr;
  logic [WIDTH-1:0] mv;

  t_ff_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cmd      (cmd),
    .steps    (steps),
    .load_val (load_val),
    .abort    (abort),
    .q_vec    (q_vec),
    .t_vec    (t_vec),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural T-FF bank sharing the controller's clock and reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_vec <= '0;
    else        q_vec <= q_vec ^ t_vec;
  end

  typedef struct {
    logic [1:0] c;
    int         s;
    logic [3:0] lv;
    int         ab_at;
    bit         junk;
    logic [3:0] exp_q;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] et, input logic eb,
                            input logic ed, input logic ew);
    chk({name, ".t_vec"}, 32'(t_vec), 32'(et));
    chk({name, ".busy"},  32'(busy),  32'(eb));
    chk({name, ".done"},  32'(done),  32'(ed));
    chk({name, ".wrap"},  32'(wrap),  32'(ew));
  endtask

  task automatic step(input logic st, input logic [1:0] c, input logic [CW-1:0] s,
                      input logic [3:0] lv, input logic ab);
    @(negedge clk);
    start = st; cmd = c; steps = s; load_val = lv; abort = ab;
    #1;
  endtask

  // One command from IDLE to IDLE; expectations come from value arithmetic on mv.
  task automatic do_cmd(input logic [1:0] c, input int s, input logic [3:0] lv,
                        input int ab_at, input bit junk);
    logic [3:0] nv;
    logic [3:0] tgt;
    bit aborted;
    aborted = 1'b0;
    step(1'b1, c, CW'(s), lv, 1'b0);
    expect_out("accept", 4'h0, 1'b0, 1'b0, 1'b0);
    if (c <= 2'd1) begin
      for (int k = 0; k < s && !aborted; k++) begin
        nv = (c == 2'd0) ? mv + 4'd1 : mv - 4'd1;
        step(junk, 2'd3, CW'($urandom), 4'($urandom), k == ab_at);
        expect_out("run", (k == ab_at) ? 4'h0 : (mv ^ nv), 1'b1, 1'b0,
                   (c == 2'd0) ? (mv == 4'hF) : (mv == 4'h0));
        if (k == ab_at) aborted = 1'b1;
        else            mv = nv;
      end
    end else begin
      tgt = (c == 2'd2) ? lv : 4'h0;
      step(junk, 2'd2, CW'($urandom), 4'($urandom), ab_at == 0);
      expect_out("apply", (ab_at == 0) ? 4'h0 : (mv ^ tgt), 1'b1, 1'b0, 1'b0);
      if (ab_at == 0) aborted = 1'b1;
      else            mv = tgt;
    end
    if (!aborted) begin
      step(junk, 2'd3, 8'd5, 4'($urandom), 1'($urandom));
      expect_out("done", 4'h0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
    expect_out("idle", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("bank_q", 32'(q_vec), 32'(mv));
  endtask

  initial begin
    nvec = 0; nerr = 0; mv = 4'h0;
    reset = 1'b0; start = 1'b1; cmd = 2'd2; steps = 8'd3; load_val = 4'h9; abort = 1'b0;

    tbl[0]  = '{c: 2'd0, s: 5, lv: 4'h0, ab_at: -1, junk: 1'b1, exp_q: 4'h5};
    tbl[1]  = '{c: 2'd2, s: 0, lv: 4'hA, ab_at: -1, junk: 1'b0, exp_q: 4'hA};
    tbl[2]  = '{c: 2'd3, s: 0, lv: 4'h7, ab_at: -1, junk: 1'b0, exp_q: 4'h0};
    tbl[3]  = '{c: 2'd1, s: 2, lv: 4'h0, ab_at: -1, junk: 1'b0, exp_q: 4'hE};
    tbl[4]  = '{c: 2'd3, s: 0, lv: 4'h0, ab_at: -1, junk: 1'b1, exp_q: 4'h0};
    tbl[5]  = '{c: 2'd0, s: 8, lv: 4'h0, ab_at: 2,  junk: 1'b0, exp_q: 4'h2};
    tbl[6]  = '{c: 2'd0, s: 0, lv: 4'h0, ab_at: -1, junk: 1'b0, exp_q: 4'h2};
    tbl[7]  = '{c: 2'd2, s: 0, lv: 4'h2, ab_at: -1, junk: 1'b0, exp_q: 4'h2};
    tbl[8]  = '{c: 2'd1, s: 3, lv: 4'h0, ab_at: -1, junk: 1'b1, exp_q: 4'hF};
    tbl[9]  = '{c: 2'd0, s: 1, lv: 4'h0, ab_at: -1, junk: 1'b0, exp_q: 4'h0};
    tbl[10] = '{c: 2'd2, s: 0, lv: 4'h9, ab_at: 0,  junk: 1'b0, exp_q: 4'h0};
    tbl[11] = '{c: 2'd0, s: 20, lv: 4'h0, ab_at: -1, junk: 1'b1, exp_q: 4'h4};

    #3;
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    #1;
    expect_out("post_reset", 4'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_cmd(tbl[i].c, tbl[i].s, tbl[i].lv, tbl[i].ab_at, tbl[i].junk);
      chk("tbl_q", 32'(q_vec), 32'(tbl[i].exp_q));
    end

    for (int n = 0; n < 40; n++) begin
      logic [1:0] c;
      int s;
      int ab;
      c  = 2'($urandom);
      s  = int'($urandom_range(0, 20));
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = (c >= 2'd2 || s == 0) ? 0 : int'($urandom_range(0, s - 1));
      do_cmd(c, s, 4'($urandom), ab, 1'($urandom));
    end

    // abort with start in IDLE: command must not be accepted
    step(1'b1, 2'd2, 8'd0, ~mv, 1'b1);
    expect_out("abort_start", 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
    expect_out("abort_start_next", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("abort_start_q", 32'(q_vec), 32'(mv));

    // reset asserted mid-RUN
    step(1'b1, 2'd0, 8'd8, 4'h0, 1'b0);
    step(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
    expect_out("pre_reset_run", mv ^ (mv + 4'd1), 1'b1, 1'b0, mv == 4'hF);
    step(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_out("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_q", 32'(q_vec), 32'h0);
    mv = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
      expect_out("after_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    end
    do_cmd(2'd0, 3, 4'h0, -1, 1'b0);
    chk("restart_q", 32'(q_vec), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
